// File: rtl/hdmi_packet_pkg.sv
// Shared packet-type codes, source identifiers and info-frame mask indices
// for the HDMI data-island packet scheduler.
package hdmi_packet_pkg;

    localparam int INFO_NUM = 3;

    // Bit positions inside the 3-bit info-frame enable/pending masks
    localparam int INFO_AVI = 0;
    localparam int INFO_AIF = 1;
    localparam int INFO_SPD = 2;

    localparam logic [7:0] TYPE_NULL  = 8'h00;
    localparam logic [7:0] TYPE_ACR   = 8'h01;
    localparam logic [7:0] TYPE_AUDIO = 8'h02;
    localparam logic [7:0] TYPE_AVI   = 8'h82;
    localparam logic [7:0] TYPE_AIF   = 8'h84;
    localparam logic [7:0] TYPE_SPD   = 8'h83;

    typedef enum logic [2:0] {
        SRC_ACR,
        SRC_AUDIO,
        SRC_AVI,
        SRC_AIF,
        SRC_SPD
    } source_e;

    typedef struct packed {
        logic [23:0]       header;
        logic [3:0][55:0]  sub;
        logic [7:0]        ptype;
    } packet_t;

endpackage

// File: rtl/info_frame_tracker.sv
// Per-field info-frame pending flags (set on field end, cleared when sent)
// and a saturating count of fields that ended with frames still unsent.
module info_frame_tracker
    import hdmi_packet_pkg::*;
#(
    parameter logic [INFO_NUM-1:0] INFO_FRAME_ENABLE = 3'b111,
    parameter int                  OVERRUN_WIDTH     = 8
) (
    input  logic                     clk_pixel,
    input  logic                     reset,
    input  logic                     video_field_end,
    input  logic [INFO_NUM-1:0]      sent_mask,
    output logic [INFO_NUM-1:0]      info_pending,
    output logic [OVERRUN_WIDTH-1:0] overrun_count
);

    logic [INFO_NUM-1:0] unsent;

    // A frame going out on this very cycle counts as sent for the overrun test
    assign unsent = info_pending & ~sent_mask & INFO_FRAME_ENABLE;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            info_pending  <= '0;
            overrun_count <= '0;
        end else begin
            // NOTE: non-blocking so the flag and counter updates both see the pre-edge flags.
            if (video_field_end && (|unsent) && (overrun_count != '1))
                overrun_count <= overrun_count + 1'b1;
            // Set is OR'd in after the clear, so a coincident field end wins
            info_pending <= (info_pending & ~sent_mask)
                          | (video_field_end ? INFO_FRAME_ENABLE : '0);
        end
    end

endmodule

// File: rtl/packet_scheduler.sv
// Fixed-priority data-island packet selector (ACR > audio > AVI > AIF > SPD > null)
// with a registered output packet and one-cycle consume grants.
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter logic [INFO_NUM-1:0] INFO_FRAME_ENABLE = 3'b111,
    parameter int                  OVERRUN_WIDTH     = 8
) (
    input  logic                     clk_pixel,
    input  logic                     reset,
    input  logic                     packet_enable,
    input  logic                     video_field_end,
    input  logic                     acr_pending,
    input  logic                     audio_pending,
    input  logic [23:0]              acr_header,
    input  logic [23:0]              audio_header,
    input  logic [23:0]              avi_header,
    input  logic [23:0]              aif_header,
    input  logic [23:0]              spd_header,
    input  logic [3:0][55:0]         acr_sub,
    input  logic [3:0][55:0]         audio_sub,
    input  logic [3:0][55:0]         avi_sub,
    input  logic [3:0][55:0]         aif_sub,
    input  logic [3:0][55:0]         spd_sub,
    output logic [23:0]              header,
    output logic [3:0][55:0]         sub,
    output logic [7:0]               packet_type,
    output logic                     acr_grant,
    output logic                     audio_grant,
    output logic [OVERRUN_WIDTH-1:0] overrun_count
);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e              state;
    packet_t             sel_pkt;
    packet_t             out_pkt;
    source_e             sel_src;
    logic                sel_valid;
    logic [INFO_NUM-1:0] info_pending;
    logic [INFO_NUM-1:0] sent_mask;

    info_frame_tracker #(
        .INFO_FRAME_ENABLE (INFO_FRAME_ENABLE),
        .OVERRUN_WIDTH     (OVERRUN_WIDTH)
    ) u_tracker (
        .clk_pixel       (clk_pixel),
        .reset           (reset),
        .video_field_end (video_field_end),
        .sent_mask       (sent_mask),
        .info_pending    (info_pending),
        .overrun_count   (overrun_count)
    );

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        sel_pkt   = '0;
        sel_src   = SRC_ACR;
        sel_valid = 1'b0;
        sent_mask = '0;
        if (acr_pending) begin
            sel_valid = 1'b1;
            sel_src   = SRC_ACR;
            sel_pkt   = '{acr_header, acr_sub, TYPE_ACR};
        end else if (audio_pending) begin
            sel_valid = 1'b1;
            sel_src   = SRC_AUDIO;
            sel_pkt   = '{audio_header, audio_sub, TYPE_AUDIO};
        end else if (info_pending[INFO_AVI]) begin
            sel_valid           = 1'b1;
            sel_src             = SRC_AVI;
            sel_pkt             = '{avi_header, avi_sub, TYPE_AVI};
            sent_mask[INFO_AVI] = packet_enable;
        end else if (info_pending[INFO_AIF]) begin
            sel_valid           = 1'b1;
            sel_src             = SRC_AIF;
            sel_pkt             = '{aif_header, aif_sub, TYPE_AIF};
            sent_mask[INFO_AIF] = packet_enable;
        end else if (info_pending[INFO_SPD]) begin
            sel_valid           = 1'b1;
            sel_src             = SRC_SPD;
            sel_pkt             = '{spd_header, spd_sub, TYPE_SPD};
            sent_mask[INFO_SPD] = packet_enable;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state       <= IDLE;
            out_pkt     <= '0;
            acr_grant   <= 1'b0;
            audio_grant <= 1'b0;
        end else begin
            acr_grant   <= packet_enable && sel_valid && (sel_src == SRC_ACR);
            audio_grant <= packet_enable && sel_valid && (sel_src == SRC_AUDIO);
            case (state)
                IDLE: if (packet_enable) begin
                    out_pkt <= sel_pkt;
                    state   <= HOLD;
                end
                HOLD: if (packet_enable) out_pkt <= sel_pkt;
                default: state <= IDLE;
            endcase
        end
    end

    assign header      = out_pkt.header;
    assign sub         = out_pkt.sub;
    assign packet_type = out_pkt.ptype;

endmodule

// File: tb/tb_packet_scheduler.sv
// Scoreboard bench for packet_scheduler: a reference model predicts each
// selected packet, grant and overrun count; the DUT output is compared a cycle later.
module tb_packet_scheduler;

    localparam int OW = 8;

    typedef struct {
        logic [7:0]   ptype;
        logic [23:0]  header;
        logic [223:0] sub;
        logic         ag;
        logic         ug;
    } exp_t;

    logic             clk_pixel = 1'b0;
    logic             reset;
    logic             packet_enable;
    logic             video_field_end;
    logic             acr_pending;
    logic             audio_pending;
    logic [23:0]      acr_header, audio_header, avi_header, aif_header, spd_header;
    logic [3:0][55:0] acr_sub, audio_sub, avi_sub, aif_sub, spd_sub;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic [7:0]       packet_type;
    logic             acr_grant;
    logic             audio_grant;
    logic [OW-1:0]    overrun_count;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [2:0]    m_pend;
    logic [OW-1:0] m_ovr;

    packet_scheduler #(
        .INFO_FRAME_ENABLE (3'b111),
        .OVERRUN_WIDTH     (OW)
    ) dut (
        .clk_pixel       (clk_pixel),
        .reset           (reset),
        .packet_enable   (packet_enable),
        .video_field_end (video_field_end),
        .acr_pending     (acr_pending),
        .audio_pending   (audio_pending),
        .acr_header      (acr_header),
        .audio_header    (audio_header),
        .avi_header      (avi_header),
        .aif_header      (aif_header),
        .spd_header      (spd_header),
        .acr_sub         (acr_sub),
        .audio_sub       (audio_sub),
        .avi_sub         (avi_sub),
        .aif_sub         (aif_sub),
        .spd_sub         (spd_sub),
        .header          (header),
        .sub             (sub),
        .packet_type     (packet_type),
        .acr_grant       (acr_grant),
        .audio_grant     (audio_grant),
        .overrun_count   (overrun_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [223:0] rand_sub();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic new_contents();
        acr_header   = 24'($urandom());
        audio_header = 24'($urandom());
        avi_header   = 24'($urandom());
        aif_header   = 24'($urandom());
        spd_header   = 24'($urandom());
        acr_sub      = rand_sub();
        audio_sub    = rand_sub();
        avi_sub      = rand_sub();
        aif_sub      = rand_sub();
        spd_sub      = rand_sub();
    endtask

    // One cycle: drive at the falling edge, model, then compare at the next falling edge
    task automatic step(input logic pe, input logic vfe);
        exp_t       e;
        logic [2:0] clr;
        new_contents();
        packet_enable   = pe;
        video_field_end = vfe;
        clr = 3'b000;
        if (pe) begin
            if (acr_pending)      e = '{8'h01, acr_header, acr_sub, 1'b1, 1'b0};
            else if (audio_pending) e = '{8'h02, audio_header, audio_sub, 1'b0, 1'b1};
            else if (m_pend[0]) begin e = '{8'h82, avi_header, avi_sub, 1'b0, 1'b0}; clr = 3'b001; end
            else if (m_pend[1]) begin e = '{8'h84, aif_header, aif_sub, 1'b0, 1'b0}; clr = 3'b010; end
            else if (m_pend[2]) begin e = '{8'h83, spd_header, spd_sub, 1'b0, 1'b0}; clr = 3'b100; end
            else                  e = '{8'h00, 24'h0, 224'h0, 1'b0, 1'b0};
            sb.push_back(e);
        end
        if (vfe && ((m_pend & ~clr) != 3'b000) && (m_ovr != {OW{1'b1}}))
            m_ovr = m_ovr + 1'b1;
        m_pend = (m_pend & ~clr) | (vfe ? 3'b111 : 3'b000);
        @(negedge clk_pixel);
        packet_enable   = 1'b0;
        video_field_end = 1'b0;
        if (pe) begin
            if (sb.size() == 0) begin
                check("scoreboard_empty", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("packet_type", packet_type, e.ptype);
                check("header", header, e.header);
                check("sub", sub, e.sub);
                check("acr_grant", acr_grant, e.ag);
                check("audio_grant", audio_grant, e.ug);
            end
        end else begin
            check("acr_grant_idle", acr_grant, 1'b0);
            check("audio_grant_idle", audio_grant, 1'b0);
        end
        check("overrun_count", overrun_count, m_ovr);
    endtask

    // Reset with packet_enable and video_field_end held high; both must be ignored
    task automatic do_reset();
        reset           = 1'b1;
        packet_enable   = 1'b1;
        video_field_end = 1'b1;
        repeat (2) @(negedge clk_pixel);
        reset           = 1'b0;
        packet_enable   = 1'b0;
        video_field_end = 1'b0;
        m_pend = 3'b000;
        m_ovr  = '0;
        sb.delete();
        check("rst_packet_type", packet_type, 8'h00);
        check("rst_header", header, 24'h0);
        check("rst_sub", sub, 224'h0);
        check("rst_acr_grant", acr_grant, 1'b0);
        check("rst_audio_grant", audio_grant, 1'b0);
        check("rst_overrun", overrun_count, 8'h00);
    endtask

    initial begin
        acr_pending   = 1'b0;
        audio_pending = 1'b0;
        new_contents();
        @(negedge clk_pixel);
        do_reset();

        // Nothing pending: null, no grant
        step(1'b1, 1'b0);

        // One field of info frames drains in AVI, AIF, SPD order, then null
        step(1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0);

        // ACR beats audio beats AVI
        step(1'b0, 1'b1);
        acr_pending   = 1'b1;
        audio_pending = 1'b1;
        step(1'b1, 1'b0);
        acr_pending = 1'b0;
        step(1'b1, 1'b0);
        audio_pending = 1'b0;
        step(1'b1, 1'b0);

        // Overrun: two back-to-back fields, then saturation
        do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("overrun_one", overrun_count, 8'd1);
        repeat (300) step(1'b0, 1'b1);
        check("overrun_saturated", overrun_count, 8'd255);

        // Field end coincident with AVI selection: set wins, AVI goes out twice
        do_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("avi_first", packet_type, 8'h82);
        step(1'b1, 1'b0);
        check("avi_again", packet_type, 8'h82);

        // Reset while SPD still pending discards it
        do_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        do_reset();
        step(1'b1, 1'b0);
        check("null_after_reset", packet_type, 8'h00);

        // Mixed random traffic
        for (int i = 0; i < 400; i++) begin
            acr_pending   = ($urandom_range(0, 3) == 0);
            audio_pending = ($urandom_range(0, 2) == 0);
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
